// File: rtl/zigzag_reorder_pp.sv
// Double-buffered N x N coefficient reorder buffer: accepts a block in raster
// order and emits it in zigzag order (or raster order when bypassed).
module zigzag_reorder_pp #(
  parameter int DW = 12,
  parameter int N  = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] in_data,
  input  logic          in_zz,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_data,
  output logic          out_first,
  output logic          out_last
);

  localparam int NN = N * N;
  localparam int CW = $clog2(N);
  localparam int AW = 2 * CW;

  logic [DW-1:0] bank_q [2][NN];

  logic          wb_q, wb_d;
  logic          rb_q, rb_d;
  logic [AW-1:0] wcnt_q, wcnt_d;
  logic [AW-1:0] rcnt_q, rcnt_d;
  logic [1:0]    full_q, full_d;
  logic [1:0]    zz_q, zz_d;
  logic [CW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic          up_q, up_d;
  logic          out_valid_q, out_valid_d;
  logic          out_first_q, out_first_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_data_q, out_data_d;

  logic          wr_fire;
  logic          ld;
  logic          w_last;
  logic          r_last;
  logic [AW-1:0] rd_addr;

  assign in_ready = !full_q[wb_q];
  assign wr_fire  = in_valid && in_ready;
  assign ld       = full_q[rb_q] && (!out_valid_q || out_ready);
  assign w_last   = (wcnt_q == AW'(NN - 1));
  assign r_last   = (rcnt_q == AW'(NN - 1));
  // N is a power of two, so r*N + c is just the concatenation {r, c}.
  assign rd_addr  = zz_q[rb_q] ? {r_q, c_q} : rcnt_q;

  always_comb begin
    // NOTE: every variable gets a default first so no path infers a latch.
    wb_d        = wb_q;
    rb_d        = rb_q;
    wcnt_d      = wcnt_q;
    rcnt_d      = rcnt_q;
    full_d      = full_q;
    zz_d        = zz_q;
    r_d         = r_q;
    c_d         = c_q;
    up_d        = up_q;
    out_valid_d = out_valid_q;
    out_first_d = out_first_q;
    out_last_d  = out_last_q;
    out_data_d  = out_data_q;

    if (wr_fire) begin
      if (wcnt_q == '0) zz_d[wb_q] = in_zz;
      if (w_last) begin
        full_d[wb_q] = 1'b1;
        wb_d         = !wb_q;
        wcnt_d       = '0;
      end else begin
        wcnt_d = wcnt_q + 1'b1;
      end
    end

    // Write and read completion always target different banks, so both
    // updates to full_d can land in the same cycle.
    if (ld) begin
      out_valid_d = 1'b1;
      out_data_d  = bank_q[rb_q][rd_addr];
      out_first_d = (rcnt_q == '0);
      out_last_d  = r_last;
      if (r_last) begin
        full_d[rb_q] = 1'b0;
        rb_d         = !rb_q;
        rcnt_d       = '0;
        r_d          = '0;
        c_d          = '0;
        up_d         = 1'b1;
      end else begin
        rcnt_d = rcnt_q + 1'b1;
        if (up_q) begin
          if (c_q == CW'(N - 1)) begin
            r_d  = r_q + 1'b1;
            up_d = 1'b0;
          end else if (r_q == '0) begin
            c_d  = c_q + 1'b1;
            up_d = 1'b0;
          end else begin
            r_d = r_q - 1'b1;
            c_d = c_q + 1'b1;
          end
        end else begin
          if (r_q == CW'(N - 1)) begin
            c_d  = c_q + 1'b1;
            up_d = 1'b1;
          end else if (c_q == '0) begin
            r_d  = r_q + 1'b1;
            up_d = 1'b1;
          end else begin
            r_d = r_q + 1'b1;
            c_d = c_q - 1'b1;
          end
        end
      end
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge value of every other register.
  always_ff @(posedge clk) begin
    if (rst) begin
      wb_q        <= 1'b0;
      rb_q        <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      full_q      <= '0;
      zz_q        <= '0;
      r_q         <= '0;
      c_q         <= '0;
      up_q        <= 1'b1;
      out_valid_q <= 1'b0;
      out_first_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_data_q  <= '0;
    end else begin
      wb_q        <= wb_d;
      rb_q        <= rb_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      full_q      <= full_d;
      zz_q        <= zz_d;
      r_q         <= r_d;
      c_q         <= c_d;
      up_q        <= up_d;
      out_valid_q <= out_valid_d;
      out_first_q <= out_first_d;
      out_last_q  <= out_last_d;
      out_data_q  <= out_data_d;
    end
  end

  // NOTE: the bank RAM has no reset; stale words are never read because the
  // full flags, which are reset, gate every read.
  always_ff @(posedge clk) begin
    if (wr_fire) bank_q[wb_q][wcnt_q] <= in_data;
  end

  assign out_valid = out_valid_q;
  assign out_first = out_first_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;

endmodule

// File: tb/tb_zigzag_reorder_pp.sv
// Self-checking bench for zigzag_reorder_pp: N=8 instance against a queue-based
// reference model, plus a directed N=4 instance.
module tb_zigzag_reorder_pp;

  localparam int DW = 12;
  localparam int NN = 64;

  typedef int iq_t[$];
  typedef struct {
    logic [DW-1:0] d;
    logic          f;
    logic          l;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          in_valid, in_ready, in_zz, out_valid, out_ready, out_first, out_last;
  logic [DW-1:0] in_data, out_data;
  logic          v4_in_valid, v4_in_ready, v4_in_zz, v4_out_valid, v4_out_ready;
  logic          v4_out_first, v4_out_last;
  logic [DW-1:0] v4_in_data, v4_out_data;

  zigzag_reorder_pp #(.DW(DW), .N(8)) dut8 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_zz(in_zz),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_first(out_first), .out_last(out_last)
  );

  zigzag_reorder_pp #(.DW(DW), .N(4)) dut4 (
    .clk(clk), .rst(rst),
    .in_valid(v4_in_valid), .in_ready(v4_in_ready), .in_data(v4_in_data), .in_zz(v4_in_zz),
    .out_valid(v4_out_valid), .out_ready(v4_out_ready), .out_data(v4_out_data),
    .out_first(v4_out_first), .out_last(v4_out_last)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Zigzag scan by anti-diagonals: odd diagonals run down-left, even ones up-right.
  function automatic iq_t zz_order(int n);
    iq_t q;
    for (int d = 0; d <= 2 * n - 2; d++) begin
      if (d % 2 == 1) begin
        for (int r = 0; r < n; r++)
          if (d - r >= 0 && d - r < n) q.push_back(r * n + (d - r));
      end else begin
        for (int r = n - 1; r >= 0; r--)
          if (d - r >= 0 && d - r < n) q.push_back(r * n + (d - r));
      end
    end
    return q;
  endfunction

  iq_t           zz8, zz4;
  exp_t          exp_q[$];
  exp_t          e;
  logic [DW-1:0] blk[$];
  logic          blk_zz;
  int            cyc = 0;
  int            acc_n, out_n, first_in_cyc, last_in_cyc, first_ov_cyc, first_out_cyc, last_out_cyc;
  logic [DW-1:0] out_log[512];
  logic          hold_v = 1'b0;
  logic [DW-1:0] hold_d;
  logic          hold_f, hold_l;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: model update and output comparison on every negedge.
  initial forever begin
    @(negedge clk);
    if (hold_v) begin
      check("hold_valid", out_valid, 1);
      check("hold_data", out_data, hold_d);
      check("hold_first", out_first, hold_f);
      check("hold_last", out_last, hold_l);
    end
    hold_v = 1'b0;
    if (rst) begin
      exp_q.delete();
      blk.delete();
    end else begin
      if (in_valid && in_ready) begin
        if (blk.size() == 0) blk_zz = in_zz;
        blk.push_back(in_data);
        acc_n++;
        last_in_cyc = cyc + 1;
        if (first_in_cyc < 0) first_in_cyc = cyc + 1;
        if (blk.size() == NN) begin
          for (int k = 0; k < NN; k++) begin
            e.d = blk_zz ? blk[zz8[k]] : blk[k];
            e.f = (k == 0);
            e.l = (k == NN - 1);
            exp_q.push_back(e);
          end
          blk.delete();
        end
      end
      if (out_valid && first_ov_cyc < 0) first_ov_cyc = cyc + 1;
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("extra_output", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("out_data", out_data, e.d);
          check("out_first", out_first, e.f);
          check("out_last", out_last, e.l);
        end
        if (out_n < 512) out_log[out_n] = out_data;
        out_n++;
        if (first_out_cyc < 0) first_out_cyc = cyc + 1;
        last_out_cyc = cyc + 1;
      end
      if (out_valid && !out_ready) begin
        hold_v = 1'b1;
        hold_d = out_data;
        hold_f = out_first;
        hold_l = out_last;
      end
    end
  end

  task automatic phase_start();
    acc_n = 0; out_n = 0;
    first_in_cyc = -1; last_in_cyc = -1; first_ov_cyc = -1;
    first_out_cyc = -1; last_out_cyc = -1;
  endtask

  task automatic put(logic [DW-1:0] d, logic zz);
    int  n = 0;
    bit  ok;
    in_valid = 1'b1;
    in_data  = d;
    in_zz    = zz;
    do begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
      n++;
    end while (!ok && n < 1000);
    if (!ok) check("in_ready_timeout", 0, 1);
  endtask

  task automatic drain(int budget);
    int n = 0;
    in_valid = 1'b0;
    while ((exp_q.size() != 0 || out_valid) && n < budget) begin
      @(posedge clk);
      n++;
    end
    #1;
    check("drain_empty", exp_q.size(), 0);
  endtask

  int zz4_lit[16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};
  int zz8_head[10] = '{0, 1, 8, 16, 9, 2, 3, 10, 17, 24};
  bit rand_done;

  initial begin
    zz8 = zz_order(8);
    zz4 = zz_order(4);
    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_zz = 1'b0; out_ready = 1'b1;
    v4_in_valid = 1'b0; v4_in_data = '0; v4_in_zz = 1'b0; v4_out_ready = 1'b1;
    phase_start();

    // Model pins: hand-computed scan orders.
    for (int i = 0; i < 10; i++) check("model_zz8_head", zz8[i], zz8_head[i]);
    check("model_zz8_tail", zz8[60] * 1000000 + zz8[61] * 10000 + zz8[62] * 100 + zz8[63],
          47 * 1000000 + 55 * 10000 + 62 * 100 + 63);
    for (int i = 0; i < 16; i++) check("model_zz4", zz4[i], zz4_lit[i]);

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_first", out_first, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst4_in_ready", v4_in_ready, 1);
    check("rst4_out_valid", v4_out_valid, 0);
    @(posedge clk); #1;

    // Single zigzag block, ramp data.
    phase_start();
    for (int i = 0; i < NN; i++) put(DW'(i), 1'b1);
    drain(300);
    check("t1_latency", first_ov_cyc - last_in_cyc, 2);
    check("t1_count", out_n, 64);
    for (int i = 0; i < 6; i++) check("t1_lit_head", out_log[i], zz8_head[i]);
    check("t1_lit_60", out_log[60], 47);
    check("t1_lit_61", out_log[61], 55);
    check("t1_lit_62", out_log[62], 62);
    check("t1_lit_63", out_log[63], 63);

    // Bypass block, then zigzag block whose in_zz drops after the first word.
    phase_start();
    for (int i = 0; i < NN; i++) put(DW'(i), 1'b0);
    put(DW'(0), 1'b1);
    for (int i = 1; i < NN; i++) put(DW'(i), 1'b0);
    drain(400);
    check("t2_bypass_10", out_log[10], 10);
    check("t2_bypass_63", out_log[63], 63);
    check("t2_zz_2", out_log[66], 8);
    check("t2_zz_61", out_log[125], 55);
    check("t2_count", out_n, 128);

    // N=4 instance, directed.
    begin
      int k = 0;
      int n = 0;
      for (int i = 0; i < 16; i++) begin
        v4_in_valid = 1'b1; v4_in_data = DW'(i); v4_in_zz = 1'b1;
        @(negedge clk);
        if (!v4_in_ready) check("n4_in_ready", v4_in_ready, 1);
        @(posedge clk); #1;
      end
      v4_in_valid = 1'b0;
      while (k < 16 && n < 100) begin
        @(negedge clk);
        if (v4_out_valid && v4_out_ready) begin
          check("n4_data", v4_out_data, zz4_lit[k]);
          check("n4_first", v4_out_first, k == 0);
          check("n4_last", v4_out_last, k == 15);
          k++;
        end
        n++;
      end
      check("n4_count", k, 16);
      @(posedge clk); #1;
    end

    // Backpressure: three blocks with the sink stalled.
    phase_start();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 3 * NN; i++) put(DW'(i), 1'b1);
        in_valid = 1'b0;
      end
      begin
        int n = 0;
        do begin
          @(negedge clk);
          n++;
        end while (in_ready && n < 500);
        check("bp_accepted_at_stall", acc_n, 128);
        check("bp_valid", out_valid, 1);
        check("bp_first_held", out_data, 0);
        check("bp_first_flag", out_first, 1);
        repeat (20) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    drain(600);
    check("bp_count", out_n, 192);

    // Back-to-back: four blocks, continuous valid and ready.
    phase_start();
    out_ready = 1'b1;
    for (int b = 0; b < 4; b++) begin
      logic zz;
      zz = 1'($urandom_range(0, 1));
      for (int i = 0; i < NN; i++) put(DW'($urandom), zz);
    end
    drain(600);
    check("b2b_in_gapfree", last_in_cyc - first_in_cyc + 1, 256);
    check("b2b_out_gapfree", last_out_cyc - first_out_cyc + 1, 256);
    check("b2b_latency", first_out_cyc - first_in_cyc, 65);
    check("b2b_count", out_n, 256);

    // Reset while block 1 drains and block 2 is partly loaded.
    phase_start();
    for (int i = 0; i < NN + 30; i++) put(DW'($urandom), 1'b1);
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_in_ready", in_ready, 1);
    check("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    phase_start();
    for (int i = 0; i < NN; i++) put(DW'($urandom), 1'b1);
    drain(300);
    check("post_rst_count", out_n, 64);

    // Random traffic with random in_zz on every word and random sink stalls.
    phase_start();
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 6 * NN; i++) begin
          if ($urandom_range(0, 3) == 0) begin
            in_valid = 1'b0;
            @(posedge clk); #1;
          end
          put(DW'($urandom), 1'($urandom_range(0, 1)));
        end
        in_valid = 1'b0;
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 9) < 6);
          @(posedge clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain(2000);
    check("rand_count", out_n, 384);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
